// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared types, item/row map and text constants for the menu settings engine
package menu_pkg;

    typedef enum logic {NAV, EDIT} menu_state_e;

    localparam int N_ITEMS = 5;
    localparam int ITEM_W  = 3;

    localparam logic [ITEM_W-1:0] ITEM_DIFF  = 3'd0;
    localparam logic [ITEM_W-1:0] ITEM_RED   = 3'd1;
    localparam logic [ITEM_W-1:0] ITEM_GREEN = 3'd2;
    localparam logic [ITEM_W-1:0] ITEM_BLUE  = 3'd3;
    localparam logic [ITEM_W-1:0] ITEM_START = ITEM_W'(N_ITEMS - 1);

    localparam logic [3:0] ROW_MENU     = 4'd0;
    localparam logic [3:0] ROW_SETTINGS = 4'd1;
    localparam logic [3:0] ROW_DIFF     = 4'd3;
    localparam logic [3:0] ROW_RED      = 4'd5;
    localparam logic [3:0] ROW_GREEN    = 4'd6;
    localparam logic [3:0] ROW_BLUE     = 4'd7;
    localparam logic [3:0] ROW_START    = 4'd9;

    localparam logic [3:0] COL_DIFF_VAL  = 4'd14;
    localparam logic [3:0] COL_COLOR_VAL = 4'd5;

    localparam logic [7:0] CH_SPACE     = 8'h20;
    localparam logic [7:0] CH_MARK      = 8'h3E;
    localparam logic [7:0] CH_EDIT_MARK = 8'h2A;
    localparam logic [7:0] CH_ZERO      = 8'h30;
    localparam logic [7:0] CH_ONE       = 8'h31;

    // Element 0 is the leftmost character on screen
    localparam logic [0:3][7:0] TXT_MENU     = "MENU";
    localparam logic [0:7][7:0] TXT_SETTINGS = "SETTINGS";
    localparam logic [0:9][7:0] TXT_DIFF     = "DIFFICULTY";
    localparam logic [0:4][7:0] TXT_START    = "START";

    function automatic logic [3:0] item_row(input logic [ITEM_W-1:0] item);
        logic [3:0] row;
        case (item)
            ITEM_DIFF:  row = ROW_DIFF;
            ITEM_RED:   row = ROW_RED;
            ITEM_GREEN: row = ROW_GREEN;
            ITEM_BLUE:  row = ROW_BLUE;
            default:    row = ROW_START;
        endcase
        return row;
    endfunction

    function automatic logic [3:0] value_col(input logic [ITEM_W-1:0] item);
        return (item == ITEM_DIFF) ? COL_DIFF_VAL : COL_COLOR_VAL;
    endfunction

endpackage

// File: rtl/menu_hex_ascii.sv
// rtl/menu_hex_ascii.sv - combinational 4-bit nibble to uppercase ASCII hex digit
module menu_hex_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    assign ascii = (nibble < 4'd10) ? (8'h30 + {4'b0, nibble}) : (8'h37 + {4'b0, nibble});

endmodule

// File: rtl/menu_settings_engine.sv
// rtl/menu_settings_engine.sv - menu text source owning difficulty/colour settings; optional MENU_CURSOR_MARK_EN
module menu_settings_engine
    import menu_pkg::*;
#(
    parameter int          MAX_DIFF  = 3,
    parameter int          DIFF_W    = 2,
    parameter int          DIFF_RST  = 1,
    parameter logic [11:0] COLOR_RST = 12'h0F0,
    parameter int          BLINK_W   = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        char_xy,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_sel,
    output logic [7:0]        char_code,
    output logic              char_hl,
    output logic [DIFF_W-1:0] difficulty_level,
    output logic [11:0]       snake_color,
    output logic              start_game
);

    menu_state_e        state_q, state_d;
    logic [ITEM_W-1:0]  cursor_q, cursor_d;
    logic [DIFF_W-1:0]  diff_q, diff_d;
    logic [11:0]        color_q, color_d;
    logic [BLINK_W-1:0] blink_q;
    logic               start_d;
    logic               up_prev, down_prev, sel_prev;

    logic up_edge, down_edge, sel_edge;
    logic up_ev, down_ev, sel_ev;

    assign up_edge   = btn_up & ~up_prev;
    assign down_edge = btn_down & ~down_prev;
    assign sel_edge  = btn_sel & ~sel_prev;

    // Opposing edges cancel; select only counts on an otherwise quiet cycle
    assign up_ev   = up_edge & ~down_edge;
    assign down_ev = down_edge & ~up_edge;
    assign sel_ev  = sel_edge & ~up_edge & ~down_edge;

    logic [DIFF_W-1:0] diff_inc, diff_dec;
    assign diff_inc = (diff_q == DIFF_W'(MAX_DIFF)) ? '0 : diff_q + 1'b1;
    assign diff_dec = (diff_q == '0) ? DIFF_W'(MAX_DIFF) : diff_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NAV;
            cursor_q   <= ITEM_DIFF;
            diff_q     <= DIFF_W'(DIFF_RST);
            color_q    <= COLOR_RST;
            blink_q    <= '0;
            start_game <= 1'b0;
            up_prev    <= 1'b0;
            down_prev  <= 1'b0;
            sel_prev   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            diff_q     <= diff_d;
            color_q    <= color_d;
            blink_q    <= blink_q + 1'b1;
            start_game <= start_d;
            up_prev    <= btn_up;
            down_prev  <= btn_down;
            sel_prev   <= btn_sel;
        end
    end

    always_comb begin
        state_d  = state_q;
        cursor_d = cursor_q;
        diff_d   = diff_q;
        color_d  = color_q;
        start_d  = 1'b0;
        case (state_q)
            NAV: begin
                if (up_ev) begin
                    cursor_d = (cursor_q == ITEM_DIFF) ? ITEM_START : cursor_q - 1'b1;
                end else if (down_ev) begin
                    cursor_d = (cursor_q == ITEM_START) ? ITEM_DIFF : cursor_q + 1'b1;
                end else if (sel_ev) begin
                    if (cursor_q == ITEM_START) start_d = 1'b1;
                    else                        state_d = EDIT;
                end
            end
            EDIT: begin
                if (sel_ev) begin
                    state_d = NAV;
                end else if (up_ev || down_ev) begin
                    case (cursor_q)
                        ITEM_DIFF:  diff_d = up_ev ? diff_inc : diff_dec;
                        ITEM_RED:   color_d[11:8] = up_ev ? color_q[11:8] + 4'd1 : color_q[11:8] - 4'd1;
                        ITEM_GREEN: color_d[7:4]  = up_ev ? color_q[7:4] + 4'd1 : color_q[7:4] - 4'd1;
                        ITEM_BLUE:  color_d[3:0]  = up_ev ? color_q[3:0] + 4'd1 : color_q[3:0] - 4'd1;
                        default:    ;
                    endcase
                end
            end
            default: state_d = NAV;
        endcase
    end

    logic [7:0] hex_r, hex_g, hex_b;

    menu_hex_ascii u_hex_r (.nibble(color_q[11:8]), .ascii(hex_r));
    menu_hex_ascii u_hex_g (.nibble(color_q[7:4]),  .ascii(hex_g));
    menu_hex_ascii u_hex_b (.nibble(color_q[3:0]),  .ascii(hex_b));

    logic [3:0] row, col, cur_row;
    logic [3:0] off3, off4, off6;
    logic [7:0] code_d;
    logic       hl_d;

    assign row     = char_xy[7:4];
    assign col     = char_xy[3:0];
    assign cur_row = item_row(cursor_q);
    assign off3    = col - 4'd3;
    assign off4    = col - 4'd4;
    assign off6    = col - 4'd6;

    always_comb begin
        code_d = CH_SPACE;
        case (row)
            ROW_MENU: begin
                if (col >= 4'd6 && col <= 4'd9) code_d = TXT_MENU[off6[1:0]];
            end
            ROW_SETTINGS: begin
                if (col >= 4'd4 && col <= 4'd11) code_d = TXT_SETTINGS[off4[2:0]];
            end
            ROW_DIFF: begin
                if (col == 4'd1)                      code_d = CH_ONE;
                else if (col >= 4'd3 && col <= 4'd12) code_d = TXT_DIFF[off3];
                else if (col == COL_DIFF_VAL)         code_d = CH_ZERO + 8'(diff_q);
            end
            ROW_RED, ROW_GREEN, ROW_BLUE: begin
                // Row 5 carries label '2', so the label is '1' + row - 4
                if (col == 4'd1) begin
                    code_d = CH_ONE + 8'(row) - 8'd4;
                end else if (col == 4'd3) begin
                    code_d = (row == ROW_RED) ? "R" : (row == ROW_GREEN) ? "G" : "B";
                end else if (col == COL_COLOR_VAL) begin
                    code_d = (row == ROW_RED) ? hex_r : (row == ROW_GREEN) ? hex_g : hex_b;
                end
            end
            ROW_START: begin
                if (col == 4'd1)                     code_d = CH_ONE + 8'd4;
                else if (col >= 4'd3 && col <= 4'd7) code_d = TXT_START[off3[2:0]];
            end
            default: ;
        endcase
`ifdef MENU_CURSOR_MARK_EN
        if (col == 4'd0 && row == cur_row) code_d = (state_q == EDIT) ? CH_EDIT_MARK : CH_MARK;
`endif
    end

    always_comb begin
        hl_d = 1'b0;
        if (row == cur_row) begin
            if (state_q == NAV) hl_d = 1'b1;
            else                hl_d = (col == value_col(cursor_q)) && blink_q[BLINK_W-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_code <= CH_SPACE;
            char_hl   <= 1'b0;
        end else begin
            char_code <= code_d;
            char_hl   <= hl_d;
        end
    end

    assign difficulty_level = diff_q;
    assign snake_color      = color_q;

endmodule

// File: tb/tb_menu_settings_engine.sv
// tb/tb_menu_settings_engine.sv - randomized and directed bench for menu_settings_engine against a screen model
module tb_menu_settings_engine;

    localparam int BLINK_W = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] char_xy;
    logic       btn_up, btn_down, btn_sel;
    logic [7:0] char_code;
    logic       char_hl;
    logic [1:0] difficulty_level;
    logic [11:0] snake_color;
    logic       start_game;

    menu_settings_engine #(.BLINK_W(BLINK_W)) dut (
        .clk(clk), .rst_n(rst_n), .char_xy(char_xy),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .char_code(char_code), .char_hl(char_hl),
        .difficulty_level(difficulty_level), .snake_color(snake_color),
        .start_game(start_game)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Reference model: menu as a list of 5 items, settings as plain numbers
    int         item_row[5] = '{3, 5, 6, 7, 9};
    int         m_cursor, m_diff, m_blink;
    bit         m_editing;
    logic [3:0] m_col[3];
    bit         pu, pd, ps;

    task automatic model_reset();
        m_cursor = 0; m_diff = 1; m_blink = 0; m_editing = 0;
        m_col[0] = 4'h0; m_col[1] = 4'hF; m_col[2] = 4'h0;
        pu = 0; pd = 0; ps = 0;
    endtask

    function automatic string place(input string line, input int at, input string s);
        for (int i = 0; i < s.len(); i++) line.putc(at + i, s.getc(i));
        return line;
    endfunction

    function automatic logic [7:0] model_char(input int r, input int c);
        string line, h;
        string chan;
        line = "                ";
        chan = "RGB";
        case (r)
            0: line = place(line, 6, "MENU");
            1: line = place(line, 4, "SETTINGS");
            3: begin
                line = place(line, 1, "1");
                line = place(line, 3, "DIFFICULTY");
                line.putc(14, 8'(48 + m_diff));
            end
            5, 6, 7: begin
                line.putc(1, 8'(48 + r - 3));
                line.putc(3, chan.getc(r - 5));
                h = $sformatf("%h", m_col[r - 5]);
                h = h.toupper();
                line.putc(5, h.getc(0));
            end
            9: begin
                line = place(line, 1, "5");
                line = place(line, 3, "START");
            end
            default: ;
        endcase
`ifdef MENU_CURSOR_MARK_EN
        if (r == item_row[m_cursor]) line.putc(0, m_editing ? "*" : ">");
`endif
        return line.getc(c);
    endfunction

    function automatic bit model_hl(input int r, input int c);
        int vcol;
        vcol = (m_cursor == 0) ? 14 : 5;
        if (r != item_row[m_cursor]) return 0;
        if (!m_editing) return 1;
        return (c == vcol) && ((m_blink % 16) >= 8);
    endfunction

    task automatic adjust(input int delta);
        if (m_cursor == 0) m_diff = (m_diff + delta + 4) % 4;
        else m_col[m_cursor - 1] = m_col[m_cursor - 1] + 4'(delta);
    endtask

    // Drive one cycle (called just after a falling edge) and check all outputs after the rising edge
    task automatic step(input bit u, input bit d, input bit s, input logic [7:0] xy);
        logic [7:0] e_code;
        bit e_hl, e_start, ue, de, se;
        btn_up = u; btn_down = d; btn_sel = s; char_xy = xy;
        e_code = model_char(int'(xy[7:4]), int'(xy[3:0]));
        e_hl = model_hl(int'(xy[7:4]), int'(xy[3:0]));
        ue = u && !pu; de = d && !pd; se = s && !ps;
        pu = u; pd = d; ps = s;
        e_start = 0;
        if (ue && !de) begin
            if (m_editing) adjust(1); else m_cursor = (m_cursor + 4) % 5;
        end else if (de && !ue) begin
            if (m_editing) adjust(-1); else m_cursor = (m_cursor + 1) % 5;
        end else if (se && !ue && !de) begin
            if (m_editing) m_editing = 0;
            else if (m_cursor == 4) e_start = 1;
            else m_editing = 1;
        end
        m_blink++;
        @(posedge clk);
        #1;
        check("code", char_code, e_code);
        check("hl", char_hl, e_hl);
        check("diff", difficulty_level, m_diff);
        check("color", snake_color, {m_col[0], m_col[1], m_col[2]});
        check("start", start_game, e_start);
        @(negedge clk);
    endtask

    task automatic press(input bit u, input bit d, input bit s);
        step(u, d, s, 8'($urandom));
        step(0, 0, 0, 8'($urandom));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_code", char_code, 8'h20);
        check("rst_hl", char_hl, 0);
        check("rst_start", start_game, 0);
        check("rst_diff", difficulty_level, 1);
        check("rst_color", snake_color, 12'h0F0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        btn_up = 0; btn_down = 0; btn_sel = 0; char_xy = 8'h00; rst_n = 1'b1;
        @(negedge clk);
        apply_reset();

        // Title letter appears one cycle after the address
        step(0, 0, 0, 8'h06);
        check("t1_menu_M", char_code, 8'h4D);

        // Cursor wraps from item 0 up to START
        press(1, 0, 0);
        step(0, 0, 0, 8'h93);
        check("t2_start_hl", char_hl, 1);
        step(0, 0, 0, 8'h33);
        check("t2_diff_nohl", char_hl, 0);

        // Red nibble edit with wrap both ways
        apply_reset();
        press(0, 1, 0);
        press(0, 0, 1);
        press(1, 0, 0);
        check("t3_red_up", snake_color, 12'h1F0);
        press(0, 1, 0);
        press(0, 1, 0);
        step(0, 0, 0, 8'h55);
        check("t3_red_F", char_code, 8'h46);
        press(0, 0, 1);

        // Difficulty wrap
        press(1, 0, 0);
        press(0, 0, 1);
        repeat (3) press(1, 0, 0);
        step(0, 0, 0, 8'h3E);
        check("t4_diff_0", char_code, 8'h30);
        press(0, 1, 0);
        step(0, 0, 0, 8'h3E);
        check("t4_diff_3", char_code, 8'h33);
        press(0, 0, 1);

        // Start pulse and held select
        press(1, 0, 0);
        step(0, 0, 1, 8'h00);
        check("t5_start_pulse", start_game, 1);
        step(0, 0, 1, 8'h00);
        check("t5_start_held", start_game, 0);
        step(0, 0, 1, 8'h00);
        step(0, 0, 0, 8'h00);
        step(1, 1, 0, 8'h00);
        step(0, 0, 0, 8'h93);
        check("t5_collision_hl", char_hl, 1);

        // Green to 7 in EDIT, then reset mid-edit
        repeat (3) press(0, 1, 0);
        press(0, 0, 1);
        repeat (8) press(1, 0, 0);
        check("t6_green_7", snake_color[7:4], 4'h7);
        apply_reset();
        step(0, 0, 0, 8'h30);
`ifdef MENU_CURSOR_MARK_EN
        check("t6_col0", char_code, 8'h3E);
`else
        check("t6_col0", char_code, 8'h20);
`endif
        check("t6_nav_hl", char_hl, 1);
        step(0, 0, 0, 8'h65);
        check("t6_green_F", char_code, 8'h46);

        // Randomized run against the model, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
